// File: rtl/control_unit.sv
// Main control decoder for a LEGv8-style pipeline: decodes instruction bits [31:21]
// into a registered control word, with a synchronous bubble (flush) and async reset.
module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [10:0] opCode,
  output logic        ALUSrc,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic [1:0]  ALUOp,
  output logic        Illegal
);

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_word_t;

  localparam logic [10:0] OP_LDUR   = 11'b11111000010;
  localparam logic [10:0] OP_STUR   = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ_HI = 8'b10110100;
  localparam logic [10:0] OP_ADD    = 11'b10001011000;
  localparam logic [10:0] OP_SUB    = 11'b11001011000;
  localparam logic [10:0] OP_AND    = 11'b10001010000;
  localparam logic [10:0] OP_ORR    = 11'b10101010000;

  localparam ctrl_word_t WORD_LDUR  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
  localparam ctrl_word_t WORD_STUR  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
  localparam ctrl_word_t WORD_CBZ   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
  localparam ctrl_word_t WORD_RTYPE = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10};

  ctrl_word_t dec_word;
  logic       dec_illegal;
  ctrl_word_t ctrl_d, ctrl_q;
  logic       illegal_d, illegal_q;

  // Equality compares (not casez) so X/Z opcode bits never match a pattern and fall to illegal.
  always_comb begin
    dec_word    = '0;
    dec_illegal = 1'b1;
    if (opCode == OP_LDUR) begin
      dec_word    = WORD_LDUR;
      dec_illegal = 1'b0;
    end else if (opCode == OP_STUR) begin
      dec_word    = WORD_STUR;
      dec_illegal = 1'b0;
    end else if (opCode[10:3] == OP_CBZ_HI) begin
      dec_word    = WORD_CBZ;
      dec_illegal = 1'b0;
    end else if ((opCode == OP_ADD) || (opCode == OP_SUB) ||
                 (opCode == OP_AND) || (opCode == OP_ORR)) begin
      dec_word    = WORD_RTYPE;
      dec_illegal = 1'b0;
    end
  end

  always_comb begin
    ctrl_d    = dec_word;
    illegal_d = dec_illegal;
    if (flush) begin
      ctrl_d    = '0;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign ALUSrc   = ctrl_q.alu_src;
  assign MemToReg = ctrl_q.mem_to_reg;
  assign RegWrite = ctrl_q.reg_write;
  assign MemRead  = ctrl_q.mem_read;
  assign MemWrite = ctrl_q.mem_write;
  assign Branch   = ctrl_q.branch;
  assign ALUOp    = ctrl_q.alu_op;
  assign Illegal  = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: table-driven reference model compared every
// cycle, plus directed vectors with hand-computed literal control words.
module tb_control_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [10:0] opCode;
  logic        ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, Illegal;
  logic [1:0]  ALUOp;

  int checks;
  int failures;

  control_unit dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .opCode   (opCode),
    .ALUSrc   (ALUSrc),
    .MemToReg (MemToReg),
    .RegWrite (RegWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Branch   (Branch),
    .ALUOp    (ALUOp),
    .Illegal  (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction table: {pattern, care mask, control word}
  localparam int NUM_ENTRIES = 7;
  localparam logic [29:0] DECODE_TABLE [NUM_ENTRIES] = '{
    {11'b11111000010, 11'b11111111111, 8'b11110000},
    {11'b11111000000, 11'b11111111111, 8'b10001000},
    {11'b10110100000, 11'b11111111000, 8'b00000101},
    {11'b10001011000, 11'b11111111111, 8'b00100010},
    {11'b11001011000, 11'b11111111111, 8'b00100010},
    {11'b10001010000, 11'b11111111111, 8'b00100010},
    {11'b10101010000, 11'b11111111111, 8'b00100010}
  };

  function automatic logic [8:0] model_decode(input logic [10:0] op, input logic fl);
    logic [29:0] entry;
    if (fl) return 9'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      entry = DECODE_TABLE[i];
      if (((op ^ entry[29:19]) & entry[18:8]) == 11'b0) return {entry[7:0], 1'b0};
    end
    return {8'b0, 1'b1};
  endfunction

  logic [7:0] exp_word;
  logic       exp_illegal;

  // Reference: output is the decode of whatever was presented at the last edge, zero under reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_word    <= 8'b0;
      exp_illegal <= 1'b0;
    end else begin
      {exp_word, exp_illegal} <= model_decode(opCode, flush);
    end
  end

  function automatic logic [7:0] dut_word();
    return {ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp};
  endfunction

  always @(negedge clk) begin
    checks++;
    if (dut_word() !== exp_word || Illegal !== exp_illegal) begin
      failures++;
      $display("[TB] FAIL model_compare t=%0t: got word=%b illegal=%b, want word=%b illegal=%b",
               $time, dut_word(), Illegal, exp_word, exp_illegal);
    end
    checks++;
    if ((MemRead && MemWrite) || (RegWrite && (MemWrite || Branch))) begin
      failures++;
      $display("[TB] FAIL exclusivity t=%0t: got word=%b, want no RegWrite/MemWrite/Branch/MemRead conflict",
               $time, dut_word());
    end
  end

  task automatic applyStimulus(input logic [10:0] op, input logic fl);
    @(negedge clk);
    opCode = op;
    flush  = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] want_word, input logic want_ill);
    checks++;
    if (dut_word() !== want_word || Illegal !== want_ill) begin
      failures++;
      $display("[TB] FAIL %s: got word=%b illegal=%b, want word=%b illegal=%b",
               name, dut_word(), Illegal, want_word, want_ill);
    end
  endtask

  localparam logic [7:0] W_LDUR = 8'b11110000;
  localparam logic [7:0] W_STUR = 8'b10001000;
  localparam logic [7:0] W_CBZ  = 8'b00000101;
  localparam logic [7:0] W_R    = 8'b00100010;
  localparam logic [7:0] W_ZERO = 8'b00000000;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    opCode   = 11'b11111000010;
    #1;
    checkOutput("reset_immediate", W_ZERO, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold", W_ZERO, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("first_edge_after_reset", W_LDUR, 1'b0);

    applyStimulus(11'b11111000010, 1'b0); checkOutput("ldur", W_LDUR, 1'b0);
    applyStimulus(11'b11111000000, 1'b0); checkOutput("stur", W_STUR, 1'b0);
    applyStimulus(11'b10110100111, 1'b0); checkOutput("cbz_111", W_CBZ, 1'b0);
    applyStimulus(11'b10110100000, 1'b0); checkOutput("cbz_000", W_CBZ, 1'b0);
    applyStimulus(11'b11111001110, 1'b0); checkOutput("illegal_7ce", W_ZERO, 1'b1);
    applyStimulus(11'b10001011000, 1'b0); checkOutput("add", W_R, 1'b0);
    applyStimulus(11'b11001011000, 1'b0); checkOutput("sub", W_R, 1'b0);
    applyStimulus(11'b10001010000, 1'b0); checkOutput("and", W_R, 1'b0);
    applyStimulus(11'b10101010000, 1'b0); checkOutput("orr", W_R, 1'b0);
    applyStimulus(11'b10001011001, 1'b0); checkOutput("illegal_add_lsb", W_ZERO, 1'b1);
    applyStimulus(11'b10110101000, 1'b0); checkOutput("illegal_near_cbz", W_ZERO, 1'b1);
    applyStimulus(11'b11111000011, 1'b0); checkOutput("illegal_near_ldur", W_ZERO, 1'b1);
    applyStimulus(11'b00000000000, 1'b0); checkOutput("illegal_zero", W_ZERO, 1'b1);
    applyStimulus(11'b11111111111, 1'b0); checkOutput("illegal_ones", W_ZERO, 1'b1);

    applyStimulus(11'b11111000010, 1'b0); checkOutput("ldur_before_flush", W_LDUR, 1'b0);
    applyStimulus(11'b11111000010, 1'b1); checkOutput("flush_ldur", W_ZERO, 1'b0);
    applyStimulus(11'b11111001110, 1'b1); checkOutput("flush_illegal", W_ZERO, 1'b0);
    applyStimulus(11'b11111000010, 1'b0); checkOutput("after_flush_ldur", W_LDUR, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("stable_hold", W_LDUR, 1'b0);

    // Asynchronous reset between edges while LDUR is active
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_midcycle", W_ZERO, 1'b0);
    applyStimulus(11'b11111000000, 1'b0); checkOutput("reset_ignores_stur", W_ZERO, 1'b0);
    applyStimulus(11'b10001011000, 1'b1); checkOutput("reset_ignores_flush", W_ZERO, 1'b0);
    @(negedge clk);
    opCode = 11'b10110100010;
    flush  = 1'b0;
    rst    = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("release_loads_cbz", W_CBZ, 1'b0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(11'($urandom_range(0, 2047)), 1'($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
